// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit.
// Takes the EX-stage ALU result as the effective address and runs a
// single-outstanding request/grant/response access on the data bus.
// Stores get byte-lane alignment and loads get extraction plus sign/zero
// extension. stall_o holds the upstream stages while an access is in flight.
//
// Handshake: a request is accepted in IDLE whenever req_valid_i is high
// (req_ready_o = 1 there). mem_req_o then stays high, with address, byte
// enables, write enable and data held stable, until the cycle mem_gnt_i is
// seen. The response is the first mem_rvalid_i after the grant cycle.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN.
//   Defined: a misaligned halfword or word request is rejected in IDLE and
//   raises err_o/rsp_valid_o the next cycle without touching the bus.
//   Undefined: the low address bits a halfword or word cannot use are ignored.
module lsu_mem_stage #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       ld_data_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [31:0]       ld_q, ld_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mis_q, mis_d;

  logic              is_b, is_h;
  logic [1:0]        off_eff;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic              trap;
  logic [31:0]       rd_sh;
  logic [31:0]       ld_ext;
  logic              busy;
  logic              rsp_ok;
  logic              timeout;

  // Decode the incoming request: access size, usable lane offset, byte enables, lane data
  always_comb begin
    is_b      = (funct3_i == 3'b000) || (funct3_i == 3'b100);
    is_h      = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    off_eff   = 2'b00;
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    if (is_b) begin
      off_eff   = addr_i[1:0];
      be_new    = 4'b0001 << off_eff;
      wdata_new = {4{wdata_i[7:0]}};
    end else if (is_h) begin
      off_eff   = {addr_i[1], 1'b0};
      be_new    = 4'b0011 << off_eff;
      wdata_new = {2{wdata_i[15:0]}};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned halfword/word requests are trapped instead of issued
  always_comb begin
    trap = (is_h && addr_i[0]) || (!is_b && !is_h && (addr_i[1:0] != 2'b00));
  end
`else
  // No alignment check: unusable low address bits are dropped above
  always_comb begin
    trap = 1'b0;
  end
`endif

  // Extract and extend the loaded lane from the returned word
  always_comb begin
    rd_sh = mem_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b100:  ld_ext = {24'h0, rd_sh[7:0]};
      3'b001:  ld_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b101:  ld_ext = {16'h0, rd_sh[15:0]};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  // Completion events; a response is only legal after the grant cycle
  always_comb begin
    busy    = (state_q == ST_REQ) || (state_q == ST_WAIT_RSP);
    rsp_ok  = (state_q == ST_WAIT_RSP) && mem_rvalid_i && !rst_i;
    timeout = busy && (cnt_q == TO_LIM) && !rsp_ok && !rst_i;
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (req_valid_i && !trap) state_d = ST_REQ;
      ST_REQ:      if (timeout)               state_d = ST_IDLE;
                   else if (mem_gnt_i)        state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: if (rsp_ok || timeout)     state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; reset forces the bus and response side quiet immediately
  always_comb begin
    req_ready_o = (state_q == ST_IDLE) && !rst_i;
    mem_req_o   = (state_q == ST_REQ) && !rst_i;
    mem_we_o    = (state_q == ST_REQ) && we_q && !rst_i;
    mem_addr_o  = addr_q;
    mem_be_o    = be_q;
    mem_wdata_o = wdata_q;
    rsp_valid_o = rsp_ok || timeout || (mis_q && !rst_i);
    err_o       = timeout || (mis_q && !rst_i);
    stall_o     = !rst_i && (((state_q == ST_IDLE) && req_valid_i) ||
                             (busy && !rsp_ok && !timeout));
    if (rsp_ok && !we_q) ld_data_o = ld_ext;
    else if (timeout)    ld_data_o = 32'h0;
    else                 ld_data_o = ld_q;
  end

  // Request capture, timeout count and load result next values
  always_comb begin
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    ld_d    = ld_q;
    mis_d   = 1'b0;
    cnt_d   = busy ? (cnt_q + 8'd1) : 8'd0;
    if ((state_q == ST_IDLE) && req_valid_i) begin
      if (trap) begin
        mis_d = 1'b1;
      end else begin
        addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
        be_d    = be_new;
        wdata_d = wdata_new;
        off_d   = off_eff;
        f3_d    = funct3_i;
        we_d    = is_store_i;
      end
    end
    if (rsp_ok && !we_q) ld_d = ld_ext;
    else if (timeout)    ld_d = 32'h0;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      ld_q    <= 32'h0;
      cnt_q   <= 8'd0;
      mis_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit for the MEM stage of the 5-stage pipeline. It consumes the EX-stage ALU result as the effective address and drives a single-outstanding data-memory bus with a request/grant/response handshake. It performs byte-lane alignment for stores and extract/sign-extension for loads. It raises a stall to the hazard unit while an access is in flight.

Parameters:
ADDR_W, 32, address width of mem_addr_o
TIMEOUT_CYC, 255, cycles without response before the bus-error path fires (8-bit counter)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  MEM-stage instruction is a load or store
req_ready_o  out  1  unit can accept a request this cycle
is_store_i  in  1  1 = store, 0 = load
funct3_i  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  in  32  effective address (ALU output)
wdata_i  in  32  store data (rs2)
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write enable
mem_addr_o  out  ADDR_W  word-aligned address, bits[1:0] = 0
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-shifted store data
mem_gnt_i  in  1  bus accepted the request
mem_rvalid_i  in  1  response valid (loads and stores both get one)
mem_rdata_i  in  32  read word
rsp_valid_o  out  1  1-cycle pulse: access complete
ld_data_o  out  32  aligned, extended load result; held until the next rsp_valid_o
stall_o  out  1  freeze upstream stages
err_o  out  1  1-cycle pulse: misaligned access or bus timeout

Behaviour:
- Reset: FSM = IDLE; mem_req_o, mem_we_o, rsp_valid_o and err_o are 0; mem_be_o, mem_addr_o, mem_wdata_o and ld_data_o are 0; timeout counter is 0.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE: req_ready_o = 1.
  - On req_valid_i, register the address, data, funct3 and direction, then go to REQ.
  - stall_o is asserted combinationally in the same cycle as req_valid_i in IDLE.
- REQ: mem_req_o = 1, with address, be, we and wdata held stable.
  - Stay in REQ until mem_gnt_i = 1, then go to WAIT_RSP.
- WAIT_RSP: mem_req_o = 0.
  - On mem_rvalid_i: pulse rsp_valid_o; for loads, update ld_data_o; go to IDLE.
  - mem_rvalid_i in the same cycle as mem_gnt_i is ignored; the response is sampled from the cycle after grant.
- stall_o = 1 in REQ and WAIT_RSP. It deasserts in the cycle rsp_valid_o pulses.
- Minimum latency: request in cycle 0, grant in cycle 1, rvalid in cycle 2, rsp_valid_o in cycle 2.
- Byte enables and store lanes (o = addr[1:0]):
  - B: be = 0001 << o; wdata = {4{wdata_i[7:0]}}.
  - H: be = 0011 << o; wdata = {2{wdata_i[15:0]}}.
  - W: be = 1111; wdata = wdata_i.
  - Loads also drive the width-correct be.
- Load extraction:
  - byte = rdata >> (8*o), then sign- or zero-extend [7:0].
  - half = rdata >> (8*o), then extend [15:0].
  - Word is passed through unchanged.
- Illegal funct3 (011, 110, 111) is treated as W.
- Timeout:
  - The counter increments in REQ and WAIT_RSP and clears on IDLE entry.
  - At TIMEOUT_CYC: pulse err_o, pulse rsp_valid_o with ld_data_o = 0, go to IDLE.
- req_valid_i while busy is ignored; the hazard unit holds the instruction via stall_o.
- rst_i mid-access: immediately return to IDLE, drop mem_req_o, and discard any later stray mem_rvalid_i.
  - The bus side is responsible for flushing its own state on reset.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: the misaligned check runs in IDLE. Misaligned means H with addr[0] = 1, or W with addr[1:0] != 0.
  - A misaligned request never enters REQ and issues no bus request.
  - The next cycle pulses err_o and rsp_valid_o, with ld_data_o unchanged and stall_o high for exactly 1 cycle.
- Not defined: no check is made.
  - H uses o with addr[0] forced to 0.
  - W uses o = 0, ignoring addr[1:0].
  - err_o fires only on timeout.

Test Plan:
- Store SB to 0x1003 with wdata 0xAABBCCDD, grant and rvalid next cycles -> mem_addr_o = 0x1000, be = 1000, wdata = 0xDDDDDDDD, mem_we_o = 1, rsp_valid_o 2 cycles after request.
- LB from 0x2002 with rdata 0x12F45678 -> ld_data_o = 0xFFFFFFF4. LBU from the same address -> 0x000000F4. LHU from 0x2002 -> 0x000012F4.
- LW with grant delayed 3 cycles and rvalid 2 cycles after that -> stall_o high for all 6 cycles, mem_req_o high for exactly 4 cycles, ld_data_o = mem_rdata_i.
- No rvalid after grant -> err_o and rsp_valid_o pulse when the counter reaches 255, ld_data_o = 0, FSM back in IDLE.
- rst_i asserted in WAIT_RSP, then rvalid arrives the following cycle -> no rsp_valid_o, all outputs at reset values.
- LSU_MISALIGN_TRAP_EN defined, LW at 0x3001 -> mem_req_o never asserted, err_o = 1 the next cycle. Not defined -> bus address 0x3000, be = 1111.
